// File: rtl/cpu_pkg.sv
// Shared CPU-side constants plus the prefetch buffer state encoding.
package cpu_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RV_NOP = 32'h0000_0013;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_DRAIN = 1'b1
  } pf_state_e;
endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous instruction-word FIFO with flush; the head word is readable combinationally.
module ifetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [XLEN-1:0]        wdata_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output logic [XLEN-1:0]        rdata_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [XLEN-1:0] mem_d [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) begin
        mem_d[wptr_q] = wdata_i;
        wptr_d        = wptr_q + AW'(1);
      end else begin
        wptr_d = wptr_q;
      end
      if (pop_i) begin
        rptr_d = rptr_q + AW'(1);
      end else begin
        rptr_d = rptr_q;
      end
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '{default: '0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/ifetch_prefetch_buf.sv
// Sequential instruction prefetcher: streams words ahead of the PC into a FIFO and flushes
// on any PC redirect, discarding responses that were already in flight.
module ifetch_prefetch_buf
  import cpu_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] cpu_addr_i,
  output logic [XLEN-1:0] cpu_rdata_o,
  output logic            cpu_valid_o,
  input  logic            cpu_advance_i,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_addr_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i
);
  localparam int          CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] head_addr_q, head_addr_d;
  logic [XLEN-1:0] fetch_addr_q, fetch_addr_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic            req_pend_q, req_pend_d;
  logic            req_stale_q, req_stale_d;
  pf_state_e       state_q, state_d;

  logic [XLEN-1:0] fifo_rdata_s;
  logic [CW-1:0]   fifo_count_s;
  logic [XLEN-1:0] redirect_addr_s;
  logic            mismatch_s, hit_s, issue_s, gnt_s, push_s, pop_s, drop_s;
  logic            addr_lsb_unused_s;

  // The core may present a byte address; only the word index takes part in matching.
  assign addr_lsb_unused_s = ^cpu_addr_i[1:0];
  assign redirect_addr_s   = {cpu_addr_i[XLEN-1:2], 2'b00};
  assign mismatch_s        = cpu_addr_i[XLEN-1:2] != head_addr_q[XLEN-1:2];
  assign hit_s             = (fifo_count_s != '0) && !mismatch_s;
  assign cpu_valid_o       = hit_s && (state_q == S_RUN);
  assign cpu_rdata_o       = cpu_valid_o ? fifo_rdata_s : RV_NOP;

  // A held request stays on the bus; a new one needs FIFO room and a free in-flight slot.
  assign issue_s   = rst_n && !req_pend_q && !mismatch_s
                     && (({1'b0, fifo_count_s} + {1'b0, outst_q}) < DEPTH_W)
                     && (({1'b0, outst_q} + {1'b0, discard_q}) < DEPTH_W);
  assign mem_req_o  = req_pend_q || issue_s;
  assign mem_addr_o = req_pend_q ? req_addr_q : fetch_addr_q;
  assign gnt_s      = mem_req_o && mem_gnt_i;
  assign drop_s     = mem_rvalid_i && (discard_q != '0);
  assign push_s     = mem_rvalid_i && (discard_q == '0) && (outst_q != '0);
  assign pop_s      = cpu_valid_o && cpu_advance_i;

  always_comb begin
    head_addr_d  = head_addr_q;
    fetch_addr_d = fetch_addr_q;
    outst_d      = outst_q + CW'(gnt_s && !req_stale_q) - CW'(push_s);
    discard_d    = discard_q + CW'(gnt_s && req_stale_q) - CW'(drop_s);
    req_pend_d   = mem_req_o && !mem_gnt_i;
    req_addr_d   = mem_addr_o;
    req_stale_d  = req_stale_q && !gnt_s;
    if (gnt_s && !req_stale_q) begin
      fetch_addr_d = fetch_addr_q + 32'd4;
    end else begin
      fetch_addr_d = fetch_addr_q;
    end
    // Handshake accounting above is applied first; a redirect then retires everything live.
    if (mismatch_s) begin
      head_addr_d  = redirect_addr_s;
      fetch_addr_d = redirect_addr_s;
      discard_d    = discard_d + outst_d;
      outst_d      = '0;
      req_stale_d  = req_stale_d || req_pend_d;
    end else if (pop_s) begin
      head_addr_d = head_addr_q + 32'd4;
    end else begin
      head_addr_d = head_addr_q;
    end
    state_d = (discard_d != '0) ? S_DRAIN : S_RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_addr_q  <= RESET_PC;
      fetch_addr_q <= RESET_PC;
      req_addr_q   <= RESET_PC;
      outst_q      <= '0;
      discard_q    <= '0;
      req_pend_q   <= 1'b0;
      req_stale_q  <= 1'b0;
      state_q      <= S_RUN;
    end else begin
      head_addr_q  <= head_addr_d;
      fetch_addr_q <= fetch_addr_d;
      req_addr_q   <= req_addr_d;
      outst_q      <= outst_d;
      discard_q    <= discard_d;
      req_pend_q   <= req_pend_d;
      req_stale_q  <= req_stale_d;
      state_q      <= state_d;
    end
  end

  ifetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .wdata_i (mem_rdata_i),
    .pop_i   (pop_s),
    .flush_i (mismatch_s),
    .rdata_o (fifo_rdata_s),
    .count_o (fifo_count_s)
  );
endmodule

// File: tb/tb_ifetch_prefetch_buf.sv
// Bench for ifetch_prefetch_buf: an in-order variable-latency memory model and a core model
// that checks every delivered word against the memory image and the expected fetch stream.
module tb_ifetch_prefetch_buf;
  import cpu_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_rdata;
  logic        cpu_valid;
  logic        adv;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  ifetch_prefetch_buf #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cpu_addr_i    (cpu_addr),
    .cpu_rdata_o   (cpu_rdata),
    .cpu_valid_o   (cpu_valid),
    .cpu_advance_i (adv),
    .mem_req_o     (mem_req),
    .mem_addr_o    (mem_addr),
    .mem_gnt_i     (gnt),
    .mem_rvalid_i  (rvalid),
    .mem_rdata_i   (rdata)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } resp_t;

  resp_t       rq[$];
  logic [31:0] glog[$];
  int          n_chk = 0, n_pass = 0;
  int          cyc = 0, last_due = 0, ghost = 0;
  int          lat_min = 1, lat_max = 1, gnt_pct = 100, adv_pct = 100, gnt_force = 1;
  int          grants = 0, retired = 0;
  logic [31:0] pc, exp_fetch, pend_addr;
  bit          pend_prev, stale_pend, redir_now;

  // Memory image: each word depends only on its word address.
  function automatic logic [31:0] word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic drive_mem();
    if (gnt_force == 0) gnt = 1'b0;
    else if (gnt_force == 1) gnt = 1'b1;
    else gnt = ($urandom_range(0, 99) < gnt_pct);
    if (ghost > 0) gnt = 1'b0;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      rvalid = 1'b1;
      rdata  = word(rq[0].addr);
    end else begin
      rvalid = 1'b0;
      rdata  = 32'hDEAD_BEEF;
    end
  endtask

  task automatic redirect(input logic [31:0] x);
    cpu_addr   = x;
    pc         = x;
    exp_fetch  = {x[31:2], 2'b00};
    stale_pend = stale_pend || pend_prev;
    redir_now  = 1'b1;
  endtask

  // One clock cycle: core decision, per-cycle checks, memory bookkeeping, next inputs.
  task automatic step();
    logic [31:0] nxt;
    bit          rv;
    int          due;
    resp_t       r;
    nxt = pc;
    #1;
    adv = cpu_valid && ($urandom_range(0, 99) < adv_pct);
    #1;
    if (rst_n === 1'b0) begin
      n_chk++;
      if (mem_req !== 1'b0 || cpu_valid !== 1'b0 || cpu_rdata !== RV_NOP)
        $display("FAIL reset_outputs: req=%b valid=%b rdata=%h, expected 0 0 %h", mem_req, cpu_valid, cpu_rdata, RV_NOP);
      else n_pass++;
    end else begin
      n_chk++;
      if (cpu_valid === 1'b1 && cpu_rdata === word(cpu_addr)) n_pass++;
      else if (cpu_valid === 1'b0 && cpu_rdata === RV_NOP) n_pass++;
      else $display("FAIL rdata: pc=%h valid=%b rdata=%h, expected %h (or NOP when invalid)", cpu_addr, cpu_valid, cpu_rdata, word(cpu_addr));
      if (pend_prev) begin
        n_chk++;
        if (mem_req !== 1'b1 || mem_addr !== pend_addr)
          $display("FAIL req_hold: req=%b addr=%h, expected 1 %h", mem_req, mem_addr, pend_addr);
        else n_pass++;
      end
      if (redir_now) begin
        n_chk++;
        if (cpu_valid !== 1'b0 || (!pend_prev && mem_req !== 1'b0))
          $display("FAIL redirect_cycle: valid=%b req=%b, expected valid 0 and no new request", cpu_valid, mem_req);
        else n_pass++;
      end
      if (mem_req && gnt) begin
        if (stale_pend) begin
          stale_pend = 1'b0;
        end else begin
          n_chk++;
          if (mem_addr !== exp_fetch) $display("FAIL fetch_addr: granted %h, expected %h", mem_addr, exp_fetch);
          else n_pass++;
          exp_fetch += 32'd4;
        end
        glog.push_back(mem_addr);
        due = cyc + $urandom_range(lat_min, lat_max);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        r.addr = mem_addr;
        r.due  = due;
        rq.push_back(r);
        grants++;
        n_chk++;
        if (rq.size() - ghost > DEPTH) $display("FAIL inflight: %0d in flight, expected at most %0d", rq.size() - ghost, DEPTH);
        else n_pass++;
      end
      pend_prev = mem_req && !gnt;
      pend_addr = mem_addr;
      if (cpu_valid && adv) begin
        retired++;
        nxt = pc + 32'd4;
      end
    end
    redir_now = 1'b0;
    rv = rvalid;
    @(posedge clk);
    #1;
    cyc++;
    if (rv && rq.size() > 0) begin
      void'(rq.pop_front());
      if (ghost > 0) ghost--;
    end
    pc       = nxt;
    cpu_addr = nxt;
    drive_mem();
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst_n      = 1'b0;
    ghost      = rq.size();
    pc         = 32'h0;
    cpu_addr   = 32'h0;
    exp_fetch  = 32'h0;
    pend_prev  = 1'b0;
    stale_pend = 1'b0;
    redir_now  = 1'b0;
    adv        = 1'b0;
    drive_mem();
    repeat (n) step();
    rst_n = 1'b1;
    glog.delete();
    grants  = 0;
    retired = 0;
    #1;
  endtask

  task automatic cfg(input int gf, input int gp, input int lmin, input int lmax, input int ap);
    gnt_force = gf; gnt_pct = gp; lat_min = lmin; lat_max = lmax; adv_pct = ap;
    drive_mem();
  endtask

  task automatic test_reset();
    cfg(1, 100, 1, 1, 100);
    do_reset(3);
  endtask

  task automatic test_first_fetch();
    cfg(1, 100, 1, 1, 0);
    do_reset(2);
    n_chk++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0 || cpu_valid !== 1'b0 || cpu_rdata !== RV_NOP)
      $display("FAIL first_req: req=%b addr=%h valid=%b rdata=%h, expected 1 0 0 %h", mem_req, mem_addr, cpu_valid, cpu_rdata, RV_NOP);
    else n_pass++;
    step();
    n_chk++;
    if (cpu_valid !== 1'b0) $display("FAIL first_cycle1: valid=%b, expected 0", cpu_valid);
    else n_pass++;
    step();
    n_chk++;
    if (cpu_valid !== 1'b1 || cpu_rdata !== word(32'h0))
      $display("FAIL first_valid: valid=%b rdata=%h, expected 1 %h", cpu_valid, cpu_rdata, word(32'h0));
    else n_pass++;
  endtask

  task automatic test_stream();
    cfg(1, 100, 1, 1, 100);
    do_reset(2);
    for (int k = 0; k < 22; k++) begin
      if (k >= 2) begin
        n_chk++;
        if (cpu_valid !== 1'b1 || cpu_addr !== 32'(4 * (k - 2)))
          $display("FAIL stream_rate: cycle %0d valid=%b pc=%h, expected 1 %h", k, cpu_valid, cpu_addr, 32'(4 * (k - 2)));
        else n_pass++;
      end
      step();
    end
    for (int i = 0; i < glog.size(); i++) begin
      n_chk++;
      if (glog[i] !== 32'(4 * i)) $display("FAIL stream_order: grant %0d addr=%h, expected %h", i, glog[i], 32'(4 * i));
      else n_pass++;
    end
  endtask

  task automatic test_fill();
    cfg(1, 100, 1, 1, 0);
    do_reset(2);
    repeat (12) step();
    n_chk++;
    if (grants != 4 || mem_req !== 1'b0 || cpu_valid !== 1'b1 || cpu_rdata !== word(32'h0))
      $display("FAIL fill: grants=%0d req=%b valid=%b rdata=%h, expected 4 0 1 %h", grants, mem_req, cpu_valid, cpu_rdata, word(32'h0));
    else n_pass++;
    n_chk++;
    if (glog.size() != 4 || glog[3] !== 32'hC) $display("FAIL fill_last: %0d grants, expected last addr 0xc", glog.size());
    else n_pass++;
  endtask

  task automatic test_flush_outstanding();
    int idx;
    bit seen, done;
    cfg(1, 100, 4, 4, 100);
    do_reset(2);
    for (int i = 0; i < 40 && glog.size() < 4; i++) step();
    n_chk++;
    if (rq.size() < 2) $display("FAIL flush_setup: %0d in flight, expected at least 2", rq.size());
    else n_pass++;
    idx = glog.size();
    redirect(32'h100);
    seen = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      #1;
      if (cpu_valid) begin
        n_chk++;
        if (!seen) $display("FAIL flush_early: valid=%b before word 0x100 returned, expected 0", cpu_valid);
        else n_pass++;
        done = 1'b1;
      end else begin
        if (rvalid && rq.size() > 0 && rq[0].addr == 32'h100) seen = 1'b1;
        step();
      end
    end
    n_chk++;
    if (!done || glog.size() <= idx || glog[idx] !== 32'h100)
      $display("FAIL flush_refetch: done=%b first post-redirect grant=%h, expected 1 00000100", done, (glog.size() > idx) ? glog[idx] : 32'hX);
    else n_pass++;
  endtask

  task automatic test_stall_redirect();
    int idx;
    bit done;
    cfg(1, 100, 1, 1, 100);
    do_reset(2);
    for (int i = 0; i < 30 && !(mem_req && mem_addr == 32'h10); i++) step();
    gnt_force = 0;
    gnt = 1'b0;
    for (int s = 0; s < 2; s++) begin
      step();
      n_chk++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h10) $display("FAIL stall_hold: req=%b addr=%h, expected 1 00000010", mem_req, mem_addr);
      else n_pass++;
    end
    idx = glog.size();
    redirect(32'h40);
    gnt_force = 1;
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      step();
      done = cpu_valid && cpu_addr == 32'h40;
    end
    n_chk++;
    if (!done || glog.size() < idx + 2 || glog[idx] !== 32'h10 || glog[idx + 1] !== 32'h40)
      $display("FAIL stall_redirect: done=%b grants after stall=%0d, expected 0x10 then 0x40", done, glog.size() - idx);
    else n_pass++;
  endtask

  task automatic test_reset_midflight();
    bit done;
    cfg(1, 100, 6, 6, 0);
    do_reset(2);
    redirect(32'h200);
    for (int i = 0; i < 20 && rq.size() < 3; i++) step();
    n_chk++;
    if (rq.size() < 3) $display("FAIL midreset_setup: %0d in flight, expected 3", rq.size());
    else n_pass++;
    do_reset(2);
    for (int i = 0; i < 20 && ghost > 0; i++) begin
      n_chk++;
      if (cpu_valid !== 1'b0) $display("FAIL midreset_ghost: valid=%b, expected 0", cpu_valid);
      else n_pass++;
      step();
    end
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      done = cpu_valid;
    end
    n_chk++;
    if (!done || cpu_addr !== 32'h0 || glog.size() == 0 || glog[0] !== 32'h0)
      $display("FAIL midreset_restart: done=%b pc=%h, expected restart at 00000000", done, cpu_addr);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] x;
    cfg(-1, 60, 1, 5, 70);
    do_reset(2);
    for (int i = 0; i < 800; i++) begin
      if (i == 400) x = 32'hFFFF_FFF4;
      else x = 32'($urandom_range(0, 4095));
      if ((i == 400 || $urandom_range(0, 99) < 4) && x[31:2] != pc[31:2]) redirect(x);
      step();
    end
    n_chk++;
    if (retired < 100) $display("FAIL random_progress: retired=%0d, expected at least 100", retired);
    else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    cpu_addr = 32'h0;
    adv      = 1'b0;
    gnt      = 1'b0;
    rvalid   = 1'b0;
    rdata    = 32'h0;
    pc       = 32'h0;
    @(negedge clk);
    test_reset();
    test_first_fetch();
    test_stream();
    test_fill();
    test_flush_outstanding();
    test_stall_redirect();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
